// File: rtl/pd_debug_stats_pkg.sv
// pd_debug_stats_pkg: shared state/stop-reason encodings and read-select codes
package pd_debug_stats_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3
  } state_e;
  typedef enum logic [1:0] {
    SR_NONE    = 2'd0,
    SR_WINDOW  = 2'd1,
    SR_CAPTURE = 2'd2,
    SR_ABORT   = 2'd3
  } stop_e;
  localparam logic [2:0] SEL_TOTAL  = 3'd0;
  localparam logic [2:0] SEL_F1     = 3'd1;
  localparam logic [2:0] SEL_F2     = 3'd2;
  localparam logic [2:0] SEL_CAP    = 3'd3;
  localparam logic [2:0] SEL_F1B_LO = 3'd4;
  localparam logic [2:0] SEL_F1B_HI = 3'd5;
  localparam logic [2:0] SEL_F2B_LO = 3'd6;
  localparam logic [2:0] SEL_F2B_HI = 3'd7;
endpackage

// File: rtl/pd_debug_stats_ctrl_if.sv
// pd_debug_stats_ctrl_if: CIF counter read handshake
interface pd_debug_stats_ctrl_if;
  logic        rd_req;
  logic [2:0]  rd_sel;
  logic        rd_valid;
  logic [31:0] rd_data;
  modport master (output rd_req, rd_sel, input rd_valid, rd_data);
  modport slave  (input rd_req, rd_sel, output rd_valid, rd_data);
endinterface

// File: rtl/pd_debug_sat_acc.sv
// pd_debug_sat_acc: clearable saturating accumulator
module pd_debug_sat_acc #(
  parameter int WIDTH     = 32,
  parameter int INC_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 en,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [WIDTH-1:0]     q
);
  logic [WIDTH:0] sum;
  assign sum = {1'b0, q} + {{(WIDTH + 1 - INC_WIDTH){1'b0}}, inc};
  // clear wins over accumulate; a carry out pins the count at all-ones
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
endmodule

// File: rtl/pd_debug_stats_ctrl.sv
// pd_debug_stats_ctrl: statistics window sequencer and counter bank for the PD debug pipeline
module pd_debug_stats_ctrl
  import pd_debug_stats_pkg::*;
#(
  parameter int CNT_WIDTH         = 32,
  parameter int BYTE_CNT_WIDTH    = 48,
  parameter int PACKET_SIZE_WIDTH = 12,
  parameter int WINDOW_WIDTH      = 32,
  parameter int DRAIN_CYCLES      = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         cfg_start,
  input  logic                         cfg_abort,
  input  logic [WINDOW_WIDTH-1:0]      cfg_window_pds,
  input  logic                         cfg_stop_on_capture,
  input  logic                         e_total_inc,
  input  logic                         e_field1_inc,
  input  logic                         e_field2_inc,
  input  logic                         e_capture_inc,
  input  logic                         e_field1_byte_inc,
  input  logic                         e_field2_byte_inc,
  input  logic [PACKET_SIZE_WIDTH-1:0] eq_byte_amount,
  input  logic                         e_capture_match_field1,
  output logic                         dbg_en,
  output logic [2:0]                   state_o,
  output logic [1:0]                   stop_reason,
  output logic                         e_done,
  pd_debug_stats_ctrl_if.slave         rd
);
  localparam int DW = $clog2(DRAIN_CYCLES) + 1;
  state_e                    st;
  stop_e                     sr;
  logic [DW-1:0]             dcnt;
  logic [WINDOW_WIDTH-1:0]   wcnt, wnext;
  logic                      act, go, win_hit, cap_hit;
  logic [CNT_WIDTH-1:0]      tot, f1, f2, cap;
  logic [BYTE_CNT_WIDTH-1:0] f1b, f2b;
  logic [31:0]               rd_mux;
  assign act     = st == ST_RUN || st == ST_DRAIN;
  assign go      = cfg_start && !cfg_abort && (st == ST_IDLE || st == ST_DONE);
  assign wnext   = e_total_inc && !(&wcnt) ? wcnt + WINDOW_WIDTH'(1) : wcnt;
  assign win_hit = cfg_window_pds != '0 && wnext >= cfg_window_pds;
  assign cap_hit = cfg_stop_on_capture && e_capture_match_field1;
  assign state_o = st;
  assign stop_reason = sr;
  pd_debug_sat_acc #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_tot (
    .clk, .rstn, .clr(go), .en(act && e_total_inc), .inc(1'b1), .q(tot));
  pd_debug_sat_acc #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_f1 (
    .clk, .rstn, .clr(go), .en(act && e_field1_inc), .inc(1'b1), .q(f1));
  pd_debug_sat_acc #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_f2 (
    .clk, .rstn, .clr(go), .en(act && e_field2_inc), .inc(1'b1), .q(f2));
  pd_debug_sat_acc #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_cap (
    .clk, .rstn, .clr(go), .en(act && e_capture_inc), .inc(1'b1), .q(cap));
  pd_debug_sat_acc #(.WIDTH(BYTE_CNT_WIDTH), .INC_WIDTH(PACKET_SIZE_WIDTH)) u_f1b (
    .clk, .rstn, .clr(go), .en(act && e_field1_byte_inc), .inc(eq_byte_amount), .q(f1b));
  pd_debug_sat_acc #(.WIDTH(BYTE_CNT_WIDTH), .INC_WIDTH(PACKET_SIZE_WIDTH)) u_f2b (
    .clk, .rstn, .clr(go), .en(act && e_field2_byte_inc), .inc(eq_byte_amount), .q(f2b));
  // window sequencer: abort beats start, window stop beats capture stop
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      st     <= ST_IDLE;
      sr     <= SR_NONE;
      dbg_en <= 1'b0;
      e_done <= 1'b0;
      dcnt   <= '0;
      wcnt   <= '0;
    end else begin
      e_done <= 1'b0;
      if (cfg_abort) begin
        st     <= ST_IDLE;
        sr     <= SR_ABORT;
        dbg_en <= 1'b0;
        dcnt   <= '0;
      end else if (go) begin
        st     <= ST_RUN;
        sr     <= SR_NONE;
        dbg_en <= 1'b1;
        wcnt   <= '0;
      end else if (st == ST_RUN) begin
        wcnt <= wnext;
        if (win_hit || cap_hit) begin
          st     <= ST_DRAIN;
          sr     <= win_hit ? SR_WINDOW : SR_CAPTURE;
          dbg_en <= 1'b0;
          dcnt   <= '0;
        end
      end else if (st == ST_DRAIN) begin
        dcnt <= dcnt + DW'(1);
        if (dcnt == DW'(DRAIN_CYCLES - 1)) begin
          st     <= ST_DONE;
          e_done <= 1'b1;
        end
      end
    end
  // counter select for the read port
  always_comb
    case (rd.rd_sel)
      SEL_TOTAL:  rd_mux = 32'(tot);
      SEL_F1:     rd_mux = 32'(f1);
      SEL_F2:     rd_mux = 32'(f2);
      SEL_CAP:    rd_mux = 32'(cap);
      SEL_F1B_LO: rd_mux = f1b[31:0];
      SEL_F1B_HI: rd_mux = 32'(f1b[BYTE_CNT_WIDTH-1:32]);
      SEL_F2B_LO: rd_mux = f2b[31:0];
      default:    rd_mux = 32'(f2b[BYTE_CNT_WIDTH-1:32]);
    endcase
  // one response per request, data held between responses
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rd.rd_valid <= 1'b0;
      rd.rd_data  <= '0;
    end else begin
      rd.rd_valid <= rd.rd_req;
      if (rd.rd_req) rd.rd_data <= rd_mux;
    end
endmodule

// File: tb/tb_pd_debug_stats_ctrl.sv
// tb_pd_debug_stats_ctrl: directed checks of window sequencing, saturation and reads
module tb_pd_debug_stats_ctrl;
  import pd_debug_stats_pkg::*;
  logic        clk = 0, rstn = 0, cfg_start = 0, cfg_abort = 0, cfg_stop_on_capture = 0;
  logic [31:0] cfg_window_pds = 0;
  logic        e_total_inc = 0, e_field1_inc = 0, e_field2_inc = 0, e_capture_inc = 0;
  logic        e_field1_byte_inc = 0, e_field2_byte_inc = 0, e_capture_match_field1 = 0;
  logic [11:0] eq_byte_amount = 0;
  logic        dbg_en, e_done;
  logic [2:0]  state_o;
  logic [1:0]  stop_reason;
  int          vectors = 0, miscompares = 0;
  logic [47:0] m [6];
  logic [31:0] ex, last;
  pd_debug_stats_ctrl_if rd_if ();
  pd_debug_stats_ctrl dut (
    .clk, .rstn, .cfg_start, .cfg_abort, .cfg_window_pds, .cfg_stop_on_capture,
    .e_total_inc, .e_field1_inc, .e_field2_inc, .e_capture_inc,
    .e_field1_byte_inc, .e_field2_byte_inc, .eq_byte_amount, .e_capture_match_field1,
    .dbg_en, .state_o, .stop_reason, .e_done, .rd(rd_if));
  // 100 MHz clock
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic sc(input string tag, input logic [2:0] s, input logic [1:0] r, input logic en, input logic dn);
    chk({tag, "_state"}, state_o, s);
    chk({tag, "_reason"}, stop_reason, r);
    chk({tag, "_dbg_en"}, dbg_en, en);
    chk({tag, "_done"}, e_done, dn);
  endtask
  task automatic rd(input string tag, input logic [2:0] sel, input logic [31:0] exp);
    rd_if.rd_req = 1;
    rd_if.rd_sel = sel;
    tick;
    rd_if.rd_req = 0;
    chk({tag, "_valid"}, rd_if.rd_valid, 1);
    chk(tag, rd_if.rd_data, exp);
  endtask
  function automatic logic [31:0] exp_rd(input int sel);
    case (sel)
      0, 1, 2, 3: return m[sel][31:0];
      4: return m[4][31:0];
      5: return 32'(m[4][47:32]);
      6: return m[5][31:0];
      default: return 32'(m[5][47:32]);
    endcase
  endfunction
  initial begin
    rd_if.rd_req = 0;
    rd_if.rd_sel = 0;
    #12;
    sc("reset", 0, 0, 0, 0);
    chk("reset_rd_valid", rd_if.rd_valid, 0);
    chk("reset_rd_data", rd_if.rd_data, 0);
    @(negedge clk) rstn = 1;
    tick;
    cfg_window_pds = 5;
    cfg_start = 1;
    tick;
    cfg_start = 0;
    sc("t1_start", 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      e_total_inc = 1;
      e_field1_inc = (i == 1 || i == 3);
      tick;
      sc($sformatf("t1_pd%0d", i), i < 4 ? 3'd1 : 3'd2, i < 4 ? 2'd0 : 2'd1, i < 4, 0);
    end
    e_total_inc = 0;
    e_field1_inc = 0;
    tick;
    sc("t1_done", 3, 1, 0, 1);
    e_total_inc = 1;
    tick;
    e_total_inc = 0;
    sc("t1_after", 3, 1, 0, 0);
    rd("t1_total", SEL_TOTAL, 8);
    rd("t1_f1", SEL_F1, 2);
    rd("t1_f2", SEL_F2, 0);
    cfg_window_pds = 0;
    cfg_stop_on_capture = 1;
    cfg_start = 1;
    tick;
    cfg_start = 0;
    sc("t2_start", 1, 0, 1, 0);
    rd("t2_clr", SEL_TOTAL, 0);
    for (int i = 0; i < 3; i++) begin
      e_total_inc = 1;
      e_capture_match_field1 = (i == 2);
      tick;
    end
    e_capture_match_field1 = 0;
    sc("t2_cap", 2, 2, 0, 0);
    tick;
    tick;
    e_total_inc = 0;
    tick;
    sc("t2_drain", 2, 2, 0, 0);
    tick;
    sc("t2_done", 3, 2, 0, 1);
    rd("t2_total", SEL_TOTAL, 5);
    cfg_stop_on_capture = 0;
    cfg_start = 1;
    tick;
    cfg_start = 0;
    for (int k = 0; k < 6; k++) m[k] = 0;
    for (int i = 0; i < 9; i++) begin
      e_total_inc = 1;
      e_field1_inc = (i % 2 == 0);
      e_field2_inc = (i % 2 == 1);
      e_capture_inc = (i == 2);
      e_field1_byte_inc = 1;
      e_field2_byte_inc = (i > 3);
      eq_byte_amount = 12'(100 * i + 7);
      rd_if.rd_req = 1;
      rd_if.rd_sel = 3'(i % 8);
      ex = exp_rd(i % 8);
      tick;
      m[0] += 1;
      m[1] += 48'(e_field1_inc);
      m[2] += 48'(e_field2_inc);
      m[3] += 48'(e_capture_inc);
      m[4] += 48'(eq_byte_amount);
      if (e_field2_byte_inc) m[5] += 48'(eq_byte_amount);
      chk($sformatf("t5_valid%0d", i), rd_if.rd_valid, 1);
      chk($sformatf("t5_data%0d", i), rd_if.rd_data, ex);
      last = ex;
    end
    {e_total_inc, e_field1_inc, e_field2_inc, e_capture_inc, e_field1_byte_inc, e_field2_byte_inc} = 0;
    rd_if.rd_req = 0;
    tick;
    chk("t5_idle_valid", rd_if.rd_valid, 0);
    chk("t5_hold", rd_if.rd_data, last);
    force dut.u_f1b.q = 48'hFFFF_FFFF_F000;
    #1 release dut.u_f1b.q;
    e_field1_byte_inc = 1;
    eq_byte_amount = 12'hFFF;
    tick;
    e_field1_byte_inc = 0;
    rd("t3_hi1", SEL_F1B_HI, 32'h0000_FFFF);
    rd("t3_lo1", SEL_F1B_LO, 32'hFFFF_FFFF);
    e_field1_byte_inc = 1;
    tick;
    e_field1_byte_inc = 0;
    rd("t3_hi2", SEL_F1B_HI, 32'h0000_FFFF);
    rd("t3_lo2", SEL_F1B_LO, 32'hFFFF_FFFF);
    rd("t3_f2b", SEL_F2B_LO, exp_rd(6));
    cfg_window_pds = 10;
    e_total_inc = 1;
    cfg_abort = 1;
    tick;
    e_total_inc = 0;
    cfg_abort = 0;
    sc("t4_abort", 0, 3, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick;
      sc($sformatf("t4_idle%0d", i), 0, 3, 0, 0);
    end
    rd("t4_f1", SEL_F1, exp_rd(1));
    rd("t4_f1b", SEL_F1B_LO, 32'hFFFF_FFFF);
    cfg_start = 1;
    cfg_abort = 1;
    tick;
    cfg_abort = 0;
    sc("t4_prio", 0, 3, 0, 0);
    tick;
    cfg_start = 0;
    sc("t4_restart", 1, 0, 1, 0);
    rd("t4_clr_tot", SEL_TOTAL, 0);
    rd("t4_clr_f1b", SEL_F1B_HI, 0);
    cfg_window_pds = 2;
    e_total_inc = 1;
    tick;
    tick;
    e_total_inc = 0;
    sc("t6_drain", 2, 1, 0, 0);
    rd("t6_tot", SEL_TOTAL, 2);
    #3 rstn = 0;
    #1;
    sc("t6_rst", 0, 0, 0, 0);
    chk("t6_rst_valid", rd_if.rd_valid, 0);
    chk("t6_rst_data", rd_if.rd_data, 0);
    @(negedge clk) rstn = 1;
    e_total_inc = 1;
    e_field1_inc = 1;
    tick;
    tick;
    tick;
    e_total_inc = 0;
    e_field1_inc = 0;
    sc("t6_idle", 0, 0, 0, 0);
    rd("t6_tot0", SEL_TOTAL, 0);
    rd("t6_f10", SEL_F1, 0);
    cfg_start = 1;
    tick;
    cfg_start = 0;
    e_total_inc = 1;
    tick;
    e_total_inc = 0;
    rd("t6_tot1", SEL_TOTAL, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
